// File: rtl/stack_ram_responder.sv
// stack_ram_responder: memory-side responder for the CPU RAM port.
// This block provides a word-addressed stack array and a 4-word MMIO window.
// The MMIO window holds seg1, seg2, a free-running cycle counter and a write counter.
// Reads pass through a fixed READ_LATENCY pipeline.
// After reset the array is cleared one word per cycle while busy is high.
module stack_ram_responder #(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [15:0] MMIO_BASE    = 16'hFF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [15:0] data,
    input  logic        wren,
    output logic [15:0] q,
    output logic        busy,
    output logic [15:0] seg1,
    output logic [15:0] seg2,
    output logic        err
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [16:0] DEPTH_W   = 17'(DEPTH);
    localparam logic [16:0] MMIO_TOP  = {1'b0, MMIO_BASE} + 17'd3;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic [15:0]   seg1_q, seg1_d;
    logic [15:0]   seg2_q, seg2_d;
    logic [15:0]   cyc_q, cyc_d;
    logic [15:0]   wrc_q, wrc_d;
    logic          err_q, err_d;

    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   pipe_q [READ_LATENCY];

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;
    logic [15:0]   rd_val;

    logic          hit_array;
    logic          hit_mmio;
    logic [1:0]    mmio_off;
    logic [AW-1:0] arr_idx;

    // Address decode on the sampled address; the array index is used only when hit_array is set.
    always_comb begin
        hit_array = ({1'b0, address} < DEPTH_W);
        hit_mmio  = (address >= MMIO_BASE) && ({1'b0, address} <= MMIO_TOP);
        mmio_off  = address[1:0] - MMIO_BASE[1:0];
        arr_idx   = address[AW-1:0];
    end

    // Next-state logic: clear sequencing, read value selection, write side effects, counters.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        seg1_d    = seg1_q;
        seg2_d    = seg2_q;
        cyc_d     = cyc_q + 16'd1;
        wrc_d     = wrc_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        rd_val    = '0;

        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == LAST_IDX) begin
                state_d = ST_RUN;
            end
        end else begin
            // Read side: all values are taken before this edge's updates.
            if (hit_array) begin
                rd_val = mem_q[arr_idx];
            end else if (hit_mmio) begin
                case (mmio_off)
                    2'd0:    rd_val = seg1_q;
                    2'd1:    rd_val = seg2_q;
                    2'd2:    rd_val = cyc_q;
                    default: rd_val = wrc_q;
                endcase
            end else begin
                err_d = 1'b1;
            end

            // Write side.
            if (wren) begin
                if (hit_array) begin
                    mem_we    = 1'b1;
                    mem_waddr = arr_idx;
                    mem_wdata = data;
                    wrc_d     = wrc_q + 16'd1;
                end else if (hit_mmio) begin
                    case (mmio_off)
                        2'd0: begin
                            seg1_d = data;
                            wrc_d  = wrc_q + 16'd1;
                        end
                        2'd1: begin
                            seg2_d = data;
                            wrc_d  = wrc_q + 16'd1;
                        end
                        default: err_d = 1'b1;
                    endcase
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // Array storage; no reset, its contents are zeroed by the clear sequence instead.
    always_ff @(posedge clock) begin
        if (!reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Control and MMIO registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            seg1_q    <= '0;
            seg2_q    <= '0;
            cyc_q     <= '0;
            wrc_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            seg1_q    <= seg1_d;
            seg2_q    <= seg2_d;
            cyc_q     <= cyc_d;
            wrc_q     <= wrc_d;
            err_q     <= err_d;
        end
    end

    // Read pipeline: stage 0 loads at the sample edge, and the last stage drives q.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= rd_val;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q    = pipe_q[READ_LATENCY-1];
    assign busy = (state_q == ST_CLEAR);
    assign seg1 = seg1_q;
    assign seg2 = seg2_q;
    assign err  = err_q;

endmodule
